mac_result_reader: RTL
======================

MAC_RESULT_READER -- requirements
Module: mac_result_reader

Interface
REQ-001 Parameter BITS, default 24, operand/output element width; accumulator width is 2*BITS.
REQ-002 Parameter LANES, default 4, number of accumulators captured per load (power of two, 2..16).
REQ-003 Parameter SHIFT, default 0, arithmetic right-shift applied before saturation (0..BITS).
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 load_i  input  1  capture strobe for acc_vec_i.
REQ-007 acc_vec_i  input  LANES*2*BITS  packed signed accumulators; lane k at bits [k*2*BITS +: 2*BITS].
REQ-008 ready_o  output  1  combinational; load_i is accepted this cycle.
REQ-009 m_valid  output  1  output element valid.
REQ-010 m_ready  input  1  downstream accepts element.
REQ-011 m_data  output  BITS  signed scaled/saturated element.
REQ-012 m_index  output  $clog2(LANES)  lane number of m_data.
REQ-013 m_last  output  1  high with the element of lane LANES-1.
REQ-014 m_sat  output  1  m_data was clipped.
REQ-015 drop_o  output  1  one-cycle pulse: load_i arrived while ready_o low.

Function
REQ-016 FSM states IDLE and SEND; IDLE->SEND on accepted load; SEND->IDLE on handshake (m_valid && m_ready) with m_last, unless a load is accepted in that cycle.
REQ-017 ready_o = (state==IDLE) || (m_valid && m_ready && m_last).
REQ-018 Accepted load at edge t captures all lanes into an internal buffer; m_valid=1, m_index=0, lane-0 result presented from edge t onward (1-cycle latency).
REQ-019 Back-to-back: load accepted in the cycle of the last handshake stays in SEND, index 0, new data; no bubble.
REQ-020 Each handshake advances m_index by 1 and presents the next lane on the following cycle; no skip or repeat.
REQ-021 While m_valid && !m_ready, m_data, m_index, m_last, m_sat hold stable.
REQ-022 Result per lane: v = acc >>> SHIFT (signed); v > 2^(BITS-1)-1 -> max, m_sat=1; v < -2^(BITS-1) -> min, m_sat=1; else v[BITS-1:0], m_sat=0.
REQ-023 m_data, m_index, m_last, m_sat are registers; no combinational path from acc_vec_i or m_ready to them.
REQ-024 Load when ready_o low is ignored (buffer untouched) and drop_o pulses high the next cycle for one cycle.
REQ-025 In IDLE m_valid=0; m_data/m_index/m_last/m_sat hold last values (don't-care for checking).

Reset
REQ-026 reset low asynchronously forces state=IDLE, m_valid=0, m_data=0, m_index=0, m_last=0, m_sat=0, drop_o=0, buffer=0.
REQ-027 Reset mid-SEND discards remaining lanes; after release the block is in IDLE with ready_o=1.
REQ-028 First load accepted on the first rising edge after reset release.

Structure
REQ-029 Package mac_pkg holds BITS default, typedef acc_t (signed 2*BITS), typedef elem_t (signed BITS), FSM state enum.
REQ-030 Shift-and-saturate in sub-module mac_sat (combinational, params BITS/SHIFT, outputs value and sat flag), one instance on the selected lane.
REQ-031 Lane selection is an index-driven mux on the buffer, no shift register.

Verification (BITS=24, LANES=4, SHIFT=0 unless stated)
REQ-032 Load {3,-5,100,0x7FFFFF}, m_ready=1 -> four beats 3,-5,100,0x7FFFFF, indices 0..3, m_last only on beat 4, m_sat=0, then m_valid=0.
REQ-033 Load lane0=0x0000_1000_0000, lane1=-0x0000_1000_0000 -> m_data 0x7FFFFF m_sat=1; 0x800000 m_sat=1.
REQ-034 SHIFT=8, lane0=0x1234_00 (=0x123400) -> m_data 0x001234, m_sat=0; lane1=-256 -> m_data -1.
REQ-035 m_ready toggled 1,0,0,1,... -> each element held while stalled, 4 distinct beats, none lost or duplicated.
REQ-036 load_i at beat 2 -> drop_o pulse next cycle, stream unchanged; load_i on last-beat handshake -> next cycle index 0 with new data, m_valid never drops.
REQ-037 reset low during beat 1 -> m_valid=0 immediately; after release new load streams from index 0.

Source files
------------

// File: rtl/mac_pkg.sv
//------------------------------------------------------------------------------
// mac_pkg : shared types for the MAC result reader.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mac_pkg;

    localparam int BITS_DEFAULT = 24;

    typedef logic signed [2*BITS_DEFAULT-1:0] acc_t;
    typedef logic signed [BITS_DEFAULT-1:0]   elem_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mac_sat.sv
//------------------------------------------------------------------------------
// mac_sat : arithmetic right shift of one accumulator, then saturate to BITS.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mac_sat #(
    parameter int BITS  = 24,
    parameter int SHIFT = 0
) (
    input  logic signed [2*BITS-1:0] acc_i,
    output logic signed [BITS-1:0]   value_o,
    output logic                     sat_o
);

    logic signed [2*BITS-1:0] w_shifted;
    logic        [BITS:0]     w_upper;

    assign w_shifted = acc_i >>> SHIFT;
    // Representable in BITS only if the sign bit is replicated through the top half.
    assign w_upper   = w_shifted[2*BITS-1:BITS-1];

    always_comb begin
        value_o = w_shifted[BITS-1:0];
        sat_o   = 1'b0;
        if (!((w_upper == '0) || (w_upper == '1))) begin
            sat_o   = 1'b1;
            value_o = w_shifted[2*BITS-1] ? {1'b1, {(BITS-1){1'b0}}}
                                          : {1'b0, {(BITS-1){1'b1}}};
        end
    end

endmodule

`default_nettype wire

// File: rtl/mac_result_reader.sv
//------------------------------------------------------------------------------
// mac_result_reader : captures LANES accumulators and streams them out one per
// handshake as scaled, saturated BITS-wide elements.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mac_result_reader
    import mac_pkg::*;
#(
    parameter int BITS  = BITS_DEFAULT,
    parameter int LANES = 4,
    parameter int SHIFT = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_i,
    input  logic [LANES*2*BITS-1:0]    acc_vec_i,
    output logic                       ready_o,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [BITS-1:0]            m_data,
    output logic [$clog2(LANES)-1:0]   m_index,
    output logic                       m_last,
    output logic                       m_sat,
    output logic                       drop_o
);

    localparam int                 ACC_W    = 2*BITS;
    localparam int                 IDX_W    = $clog2(LANES);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(LANES-1);

    state_t                      state_q, state_d;
    logic [LANES*ACC_W-1:0]      buf_q, buf_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [BITS-1:0]             data_q, data_d;
    logic                        last_q, last_d;
    logic                        sat_q, sat_d;
    logic                        drop_q, drop_d;

    logic                        w_hs;
    logic                        w_accept;
    logic [IDX_W-1:0]            w_sel_idx;
    logic [LANES*ACC_W-1:0]      w_src_vec;
    logic signed [ACC_W-1:0]     w_lanes [LANES];
    logic signed [BITS-1:0]      w_sat_value;
    logic                        w_sat_flag;

    assign w_hs     = m_valid && m_ready;
    assign ready_o  = (state_q == ST_IDLE) || (w_hs && last_q);
    assign w_accept = load_i && ready_o;

    // A fresh load presents lane 0 of the incoming vector on the capture edge.
    assign w_src_vec = w_accept ? acc_vec_i : buf_q;
    assign w_sel_idx = w_accept ? '0 : idx_q + IDX_W'(1);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_lanes[k] = w_src_vec[k*ACC_W +: ACC_W];
    end

    mac_sat #(
        .BITS  (BITS),
        .SHIFT (SHIFT)
    ) u_sat (
        .acc_i   (w_lanes[w_sel_idx]),
        .value_o (w_sat_value),
        .sat_o   (w_sat_flag)
    );

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        data_d  = data_q;
        last_d  = last_q;
        sat_d   = sat_q;
        drop_d  = load_i && !ready_o;

        if (w_accept) begin
            state_d = ST_SEND;
            buf_d   = acc_vec_i;
            idx_d   = '0;
            data_d  = w_sat_value;
            sat_d   = w_sat_flag;
            last_d  = 1'b0;
        end else if (w_hs) begin
            if (last_q) begin
                state_d = ST_IDLE;
            end else begin
                idx_d  = w_sel_idx;
                data_d = w_sat_value;
                sat_d  = w_sat_flag;
                last_d = (w_sel_idx == LAST_IDX);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            sat_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            last_q  <= last_d;
            sat_q   <= sat_d;
            drop_q  <= drop_d;
        end
    end

    assign m_valid = (state_q == ST_SEND);
    assign m_data  = data_q;
    assign m_index = idx_q;
    assign m_last  = last_q;
    assign m_sat   = sat_q;
    assign drop_o  = drop_q;

endmodule

`default_nettype wire
